// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder
//  Description : Packs instruction field tuples into fixed-width words and
//                writes them as a burst to consecutive instruction-memory
//                addresses. A burst is armed by start with a base address
//                and a word count. Accepted tuples are encoded immediately
//                and queued in a 2-entry FIFO. The FIFO head is presented to
//                memory with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    reset        in   asynchronous, active-low reset
//    start        in   begin a burst (only honoured in IDLE)
//    abort        in   cancel the burst; flushes FIFO, no done pulse
//    base_addr    in   first write address (latched on start)
//    length       in   words in the burst (latched on start)
//    in_valid     in   field tuple present
//    in_ready     out  tuple accepted when in_valid && in_ready
//    op_code      in   op code field          -> word[15:12]
//    ext_op_code  in   extended op code       -> word[7:4]  (register format)
//    a_index      in   A register index       -> word[11:8]
//    b_index      in   B register index       -> word[3:0]  (register format)
//    immediate    in   immediate value        -> word[7:0]  (immediate format)
//    use_imm      in   1 = immediate format, 0 = register format
//    mem_we       out  write request (FIFO non-empty while running)
//    mem_ready    in   memory accepts the write when mem_we && mem_ready
//    mem_addr     out  base address + words written (wraps silently)
//    mem_data     out  encoded word at the FIFO head
//    busy         out  high while a burst is running
//    done         out  one-cycle pulse when a burst completes
// ============================================================================
module instruction_encoder #(
    parameter int WIDTH     = 16,
    parameter int OP_BITS   = 4,
    parameter int REG_BITS  = 4,
    parameter int IMM_BITS  = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] length,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_BITS-1:0]   op_code,
    input  logic [OP_BITS-1:0]   ext_op_code,
    input  logic [REG_BITS-1:0]  a_index,
    input  logic [REG_BITS-1:0]  b_index,
    input  logic [IMM_BITS-1:0]  immediate,
    input  logic                 use_imm,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [ADDR_BITS-1:0]   base_q,    base_d;
    logic [ADDR_BITS-1:0]   len_q,     len_d;
    logic [ADDR_BITS-1:0]   acc_cnt_q, acc_cnt_d;   // tuples accepted
    logic [ADDR_BITS-1:0]   wr_cnt_q,  wr_cnt_d;    // writes retired
    logic [WIDTH-1:0]       fifo_q [2];
    logic [WIDTH-1:0]       fifo_d [2];
    logic                   rd_ptr_q,  rd_ptr_d;
    logic                   wr_ptr_q,  wr_ptr_d;
    logic [1:0]             count_q,   count_d;     // FIFO occupancy 0..2

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   run;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [ADDR_BITS-1:0]   wr_cnt_inc;
    logic [IMM_BITS-1:0]    low_field;
    logic [WIDTH-1:0]       enc_word;

    assign run        = (state_q == ST_RUN);
    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);

    // Full is judged on the registered occupancy only; a pop in the same
    // cycle does not open a slot for a push until the next cycle.
    assign in_ready   = run && !fifo_full && (acc_cnt_q < len_q);
    assign push       = in_valid && in_ready;

    assign mem_we     = run && !fifo_empty;
    assign pop        = mem_we && mem_ready;

    assign wr_cnt_inc = wr_cnt_q + 1'b1;

    // The low byte carries either the immediate or the {ext, B} pair; the
    // unused fields never reach the word.
    assign low_field  = use_imm ? immediate : {ext_op_code, b_index};
    assign enc_word   = {op_code, a_index, low_field};

    // Outputs are pure functions of registered state, so they settle right
    // after the clock edge and drop to zero the moment reset asserts.
    assign mem_addr   = base_q + wr_cnt_q;
    assign mem_data   = mem_we ? fifo_q[rd_ptr_q] : '0;
    assign busy       = run;
    assign done       = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d   = ST_RUN;
                        base_d    = base_addr;
                        len_d     = length;
                        acc_cnt_d = '0;
                        wr_cnt_d  = '0;
                        rd_ptr_d  = 1'b0;
                        wr_ptr_d  = 1'b0;
                        count_d   = 2'd0;
                    end else begin
                        // Empty burst: complete without touching memory.
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (push) begin
                    fifo_d[wr_ptr_q] = enc_word;
                    wr_ptr_d         = ~wr_ptr_q;
                    acc_cnt_d        = acc_cnt_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = ~rd_ptr_q;
                    wr_cnt_d = wr_cnt_inc;
                end
                // Push and pop together leave occupancy unchanged.
                count_d = count_q + {1'b0, push} - {1'b0, pop};

                // The last retire implies every tuple was already accepted,
                // so the FIFO is empty when leaving RUN.
                if (pop && (wr_cnt_inc == len_q)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over start, completion and any write in flight: the
        // head word is discarded without its pop being counted.
        if (abort) begin
            state_d   = ST_IDLE;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
`default_nettype wire
